aes_v2_mix_sequencer: RTL
=========================

// Module: aes_v2_mix_sequencer
//
// PURPOSE
//   Initiator for the lightweight AES MixColumns instruction interface. Takes a full
//   128-bit AES state plus direction and issues one mix instruction per column.
//   Sequence: flush, then four valid/ready transactions. Collects the four 32-bit
//   results and returns the mixed 128-bit state over a valid/ready response port.
//   Sits between the round controller and any MixColumns responder, single or multi-cycle.
//
// PARAMETERS
//   CLEAR_ON_DONE  1      1: zero the state/result registers when the response is accepted.
//   FLUSH_VALUE    32'h0  Value driven on mix_flush_data during the flush cycle.
//
// PORTS
//   clock           in   1    Single clock; all state updates on the rising edge.
//   reset           in   1    Asynchronous, active-low reset.
//   req_valid       in   1    Request present.
//   req_ready       out  1    Sequencer idle; request is accepted when req_valid && req_ready.
//   req_enc         in   1    1 = forward MixColumns, 0 = inverse.
//   req_state       in   128  Input state. Column c = [32c+31:32c]; byte 0 of each column is the low byte.
//   rsp_valid       out  1    Mixed state available.
//   rsp_ready       in   1    Consumer accepts the response.
//   rsp_state       out  128  Mixed state, same layout as req_state.
//   mix_flush       out  1    Flush strobe to the responder.
//   mix_flush_data  out  32   Flush data to the responder.
//   mix_valid       out  1    Instruction valid.
//   mix_rs1         out  32   Column word.
//   mix_rs2         out  32   Column word; identical to mix_rs1.
//   mix_enc         out  1    Direction latched from req_enc.
//   mix_ready       in   1    Responder complete. May be combinational on mix_valid.
//   mix_result      in   32   Mixed column. Sampled only when mix_valid && mix_ready.
//
// BEHAVIOUR
//   Reset values: all outputs 0, except req_ready = 1. FSM in IDLE; column index 0; registers 0.
//   FSM states and transitions:
//     IDLE  -> FLUSH  on req_valid. Latch req_state and req_enc.
//     FLUSH -> ISSUE  after exactly one cycle. mix_flush = 1; mix_flush_data = FLUSH_VALUE.
//     ISSUE -> ISSUE  on each column completion while col < 3.
//     ISSUE -> DONE   when col 3 completes.
//     DONE  -> IDLE   on rsp_ready.
//   ISSUE:
//     mix_valid = 1; mix_rs1 = mix_rs2 = column[col].
//     On mix_ready: write mix_result into result[col], then col++.
//     While mix_ready = 0: mix_valid, mix_rs1/rs2 and mix_enc hold stable.
//   Gating: mix_rs1/rs2/enc are forced to 0 whenever mix_valid = 0. Operands never leak.
//   mix_ready is ignored outside ISSUE. A spurious mix_ready in IDLE/FLUSH/DONE has no effect.
//   DONE: rsp_valid = 1 and rsp_state = result. Both hold stable until rsp_ready.
//   req_ready = 1 only in IDLE. No request overlap or queueing.
//   Latency with a single-cycle responder: request accepted at cycle 0 -> rsp_valid at cycle 6.
//     Each responder stall cycle adds 1.
//   CLEAR_ON_DONE = 1: the DONE -> IDLE transition zeroes the state and result registers.
//     rsp_state reads 0 while not in DONE.
//   Reset mid-operation: immediate return to IDLE, no response, registers cleared.
//     The responder sees mix_valid drop asynchronously.
//   Column index is 2 bits; it wraps to 0 on entering DONE.
//
// STRUCTURE
//   Shared package/header aes_v2_pkg holds:
//     - FSM encodings (IDLE=0, FLUSH=1, ISSUE=2, DONE=3)
//     - AES_COL_W = 32, AES_STATE_W = 128
//     - column slice helper
//   No sub-module: one FSM plus a 4x32 result register file.
//   The bench instantiates this block with the lightweight MixColumns unit as responder.
//
// TESTING
//   1. Forward: req_enc = 1, req_state = {c6c6c6c6, 01010101, 5c220af2, 455313db}
//      -> rsp_state = {c6c6c6c6, 01010101, 9d58dc9f, bca14d8e}. rsp_valid at cycle 6.
//   2. Inverse: req_enc = 0, req_state = {c6c6c6c6, 01010101, 9d58dc9f, bca14d8e}
//      -> rsp_state = {c6c6c6c6, 01010101, 5c220af2, 455313db}.
//   3. Stall: responder holds mix_ready = 0 for 3 cycles on col 1 (input d5d4d4d4)
//      -> mix_rs1 = d5d4d4d4 held stable; result col1 = d6d7d5d5; rsp_valid at cycle 9.
//   4. Backpressure: rsp_ready = 0 for 5 cycles
//      -> rsp_state stable, req_ready = 0; a req_valid pulse is not accepted;
//      req_ready = 1 the cycle after rsp_ready.
//   5. Reset mid-op: reset low during ISSUE col 2
//      -> all outputs 0, req_ready = 1; a new request completes normally with correct data.
//   6. Hygiene: after case 1 completes, mix_rs1/rs2 = 0 and rsp_state = 0 in IDLE.
//      A spurious mix_ready in IDLE is ignored.

Source files
------------

// File: rtl/aes_v2_mix_sequencer_pkg.sv
// Shared definitions for the AES MixColumns sequencer: FSM encoding, widths,
// and a column slice helper.
package aes_v2_mix_sequencer_pkg;

    localparam int AES_COL_W   = 32;
    localparam int AES_STATE_W = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    function automatic logic [AES_COL_W-1:0] col_slice(input logic [AES_STATE_W-1:0] s,
                                                       input logic [1:0] c);
        return s[AES_COL_W*c +: AES_COL_W];
    endfunction

endpackage

// File: rtl/aes_v2_mix_sequencer_if.sv
// MixColumns instruction bus between the sequencer (master) and a responder (slave).
interface aes_v2_mix_sequencer_if;
    import aes_v2_mix_sequencer_pkg::*;

    logic                 flush;
    logic [AES_COL_W-1:0] flush_data;
    logic                 valid;
    logic [AES_COL_W-1:0] rs1;
    logic [AES_COL_W-1:0] rs2;
    logic                 enc;
    logic                 ready;
    logic [AES_COL_W-1:0] result;

    modport master (output flush, flush_data, valid, rs1, rs2, enc,
                    input  ready, result);
    modport slave  (input  flush, flush_data, valid, rs1, rs2, enc,
                    output ready, result);
endinterface

// File: rtl/aes_v2_mix_sequencer.sv
// Issues one MixColumns instruction per column of a 128-bit AES state (after a
// single flush cycle) and returns the reassembled mixed state.
module aes_v2_mix_sequencer
    import aes_v2_mix_sequencer_pkg::*;
#(
    parameter bit                   CLEAR_ON_DONE = 1'b1,
    parameter logic [AES_COL_W-1:0] FLUSH_VALUE   = 32'h0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_enc,
    input  logic [AES_STATE_W-1:0] req_state,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [AES_STATE_W-1:0] rsp_state,
    aes_v2_mix_sequencer_if.master mix
);

    seq_state_e                  state;
    logic [1:0]                  col;
    logic [AES_STATE_W-1:0]      state_q;
    logic                        enc_q;
    logic [3:0][AES_COL_W-1:0]   result;

    // Result registers are only exposed while the response is being offered.
    assign rsp_state = rsp_valid ? result : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            col            <= 2'd0;
            state_q        <= '0;
            enc_q          <= 1'b0;
            result         <= '0;
            req_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            mix.flush      <= 1'b0;
            mix.flush_data <= '0;
            mix.valid      <= 1'b0;
            mix.rs1        <= '0;
            mix.rs2        <= '0;
            mix.enc        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state_q        <= req_state;
                        enc_q          <= req_enc;
                        req_ready      <= 1'b0;
                        mix.flush      <= 1'b1;
                        mix.flush_data <= FLUSH_VALUE;
                        state          <= FLUSH;
                    end
                end
                FLUSH: begin
                    mix.flush      <= 1'b0;
                    mix.flush_data <= '0;
                    mix.valid      <= 1'b1;
                    mix.rs1        <= col_slice(state_q, 2'd0);
                    mix.rs2        <= col_slice(state_q, 2'd0);
                    mix.enc        <= enc_q;
                    col            <= 2'd0;
                    state          <= ISSUE;
                end
                ISSUE: begin
                    if (mix.ready) begin
                        result[col] <= mix.result;
                        col         <= col + 2'd1;
                        if (col == 2'd3) begin
                            // Drop operands together with valid so nothing leaks past the last column.
                            mix.valid <= 1'b0;
                            mix.rs1   <= '0;
                            mix.rs2   <= '0;
                            mix.enc   <= 1'b0;
                            rsp_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            mix.rs1 <= col_slice(state_q, col + 2'd1);
                            mix.rs2 <= col_slice(state_q, col + 2'd1);
                        end
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        if (CLEAR_ON_DONE) begin
                            state_q <= '0;
                            enc_q   <= 1'b0;
                            result  <= '0;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
